// File: rtl/pixel_write_buffer.sv
// pixel_write_buffer: accepts drawer pixel writes, queues on-screen pixels in a
// small FIFO, and streams them as linear-address writes to the bitmap memory.
// A hardware clear sweep fills the whole screen with one color on request.
module pixel_write_buffer #(
    parameter int DEPTH    = 8,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        draw,
    input  logic [8:0]  x_in,
    input  logic [7:0]  y_in,
    input  logic [2:0]  color_in,
    output logic        full,
    output logic        empty,
    input  logic        clear_start,
    input  logic [2:0]  clear_color,
    output logic        clear_busy,
    output logic        clear_done,
    output logic        mem_we,
    output logic [16:0] mem_addr,
    output logic [2:0]  mem_data,
    input  logic        mem_ready,
    output logic [7:0]  drop_count
);

    localparam int              AW        = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [8:0]      X_LIM     = 9'(SCREEN_W);
    localparam logic [7:0]      Y_LIM     = 8'(SCREEN_H);
    localparam logic [16:0]     LAST_ADDR = 17'(SCREEN_W * SCREEN_H - 1);

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] color;
    } pix_t;

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

    // y*320 + x built from shifts; the row stride is fixed at 320 pixels.
    function automatic logic [16:0] lin_addr(input logic [8:0] px, input logic [7:0] py);
        return ({9'd0, py} << 8) + ({9'd0, py} << 6) + {8'd0, px};
    endfunction

    pix_t          fifo_q [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    pix_t          new_pix, head;

    state_t        state, state_n;
    logic          clr_pend, clr_pend_n, clr_accept;
    logic [2:0]    clr_color;
    logic          we_n, done_n;
    logic [16:0]   addr_n;
    logic [2:0]    data_n;
    logic          on_screen, push, pop, xfer;

    assign new_pix    = {x_in, y_in, color_in};
    assign head       = fifo_q[rd_ptr];
    assign full       = (count == FULL_CNT);
    assign on_screen  = (x_in < X_LIM) && (y_in < Y_LIM);
    assign push       = draw && !full && on_screen;
    assign xfer       = mem_we && mem_ready;
    assign clear_busy = (state == CLEAR);
    assign empty      = (count == '0) && !mem_we && (state != CLEAR);
    // A second clear request while one is queued or running is dropped.
    assign clr_accept = clear_start && (state != CLEAR) && !clr_pend;

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr] <= new_pix;
    end

    // FIFO pointers and registered occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // Saturating count of off-screen draws that were not blocked by full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                                 drop_count <= '0;
        else if (draw && !full && !on_screen && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end

    // Next-state and next-output logic for the write port sequencer.
    always_comb begin
        state_n    = state;
        we_n       = mem_we;
        addr_n     = mem_addr;
        data_n     = mem_data;
        done_n     = 1'b0;
        pop        = 1'b0;
        clr_pend_n = clr_pend;
        if (clr_accept) clr_pend_n = 1'b1;
        case (state)
            IDLE: begin
                if (clr_pend) begin
                    clr_pend_n = 1'b0;
                    state_n    = CLEAR;
                    we_n       = 1'b1;
                    addr_n     = '0;
                    data_n     = clr_color;
                end else if (count != '0) begin
                    pop     = 1'b1;
                    state_n = WRITE;
                    we_n    = 1'b1;
                    addr_n  = lin_addr(head.x, head.y);
                    data_n  = head.color;
                end
            end
            WRITE: begin
                if (xfer) begin
                    // A queued clear wins over remaining FIFO entries.
                    if (!clr_pend && count != '0) begin
                        pop    = 1'b1;
                        addr_n = lin_addr(head.x, head.y);
                        data_n = head.color;
                    end else begin
                        we_n    = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            CLEAR: begin
                if (xfer) begin
                    if (mem_addr == LAST_ADDR) begin
                        we_n    = 1'b0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        addr_n = mem_addr + 17'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, registered write port and clear bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            clear_done <= 1'b0;
            clr_pend   <= 1'b0;
            clr_color  <= '0;
        end else begin
            state      <= state_n;
            mem_we     <= we_n;
            mem_addr   <= addr_n;
            mem_data   <= data_n;
            clear_done <= done_n;
            clr_pend   <= clr_pend_n;
            if (clr_accept) clr_color <= clear_color;
        end
    end

endmodule

// File: doc/pixel_write_buffer.md
Name: pixel_write_buffer

Overview:
- Receiving end of the drawer pixel interface (`draw`/`x`/`y` pulses produced by ball, line and character drawers).
- Accepts pixel writes, buffers them in a small FIFO and rejects off-screen coordinates.
- Converts each (x, y) to a linear framebuffer address and writes it into the 320x240, 3-bit-color bitmap memory through a ready-stalled write port.
- Provides a hardware screen-clear sweep so drawers need not erase the screen pixel by pixel.

Parameters:
DEPTH, 8, FIFO entries (power of two, >=2)
SCREEN_W, 320, visible width in pixels
SCREEN_H, 240, visible height in pixels

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
draw  input  1  pixel write request, sampled each rising edge
x_in  input  9  pixel column
y_in  input  8  pixel row
color_in  input  3  pixel color
full  output  1  FIFO holds DEPTH entries; drawer must not assert draw
empty  output  1  FIFO empty and no write pending
clear_start  input  1  request full-screen fill with clear_color
clear_color  input  3  fill color, sampled when clear is accepted
clear_busy  output  1  clear sweep in progress
clear_done  output  1  one-cycle pulse after last clear write accepted
mem_we  output  1  write request to bitmap memory
mem_addr  output  17  linear address y*SCREEN_W + x
mem_data  output  3  write color
mem_ready  input  1  memory accepts write this cycle when high with mem_we
drop_count  output  8  saturating count of rejected off-screen pixels

Behaviour:
Reset values (asynchronous, immediate):
- FIFO emptied; state IDLE.
- mem_we=0, mem_addr=0, mem_data=0.
- full=0, empty=1, clear_busy=0, clear_done=0, drop_count=0.
- Any pending clear request discarded.

Input acceptance (each rising edge):
- draw=1, full=0, x_in<SCREEN_W, y_in<SCREEN_H: entry {x, y, color} pushed.
- draw=1, coordinate off-screen: not pushed; drop_count += 1, saturating at 255.
- draw=1 while full=1: ignored entirely; no push, no drop count.
- Push and pop on the same edge: occupancy unchanged. full is valid in that cycle.

Write port:
- A transfer occurs on an edge where mem_we=1 and mem_ready=1.
- mem_we, mem_addr and mem_data are registered.
- While mem_we=1 and mem_ready=0, mem_addr and mem_data hold stable.
- Address is computed as (y<<8)+(y<<6)+x, 17-bit, with no overflow for legal coordinates.
- Latency: draw accepted at edge E0 -> mem_we=1 after edge E1, assuming IDLE and an empty output register.
- Back-to-back transfers are allowed. With mem_ready held high, one pixel is written per clock and FIFO order is preserved.

State machine (IDLE, WRITE, CLEAR):
- IDLE:
  - Pending clear request -> CLEAR; clear_color latched; mem_addr=0; mem_data=clear_color; mem_we=1.
  - Otherwise, FIFO non-empty -> pop into output register -> WRITE.
- WRITE:
  - On transfer with no pending clear and FIFO non-empty: pop the next entry and stay in WRITE.
  - On transfer otherwise: mem_we=0 -> IDLE.
- CLEAR:
  - clear_busy=1.
  - Each transfer increments mem_addr.
  - Transfer at address SCREEN_W*SCREEN_H-1 (76799): mem_we=0, clear_done=1 for one cycle -> IDLE.
  - The FIFO keeps accepting draws during CLEAR but is not drained until after clear_done.

Clear request rules:
- clear_start while in IDLE or WRITE sets a pending-clear flag.
- The current WRITE transfer completes first; the clear then has priority over FIFO contents.
- clear_start while in CLEAR, or while a clear is already pending, is ignored.

Status outputs:
- empty=1 only when FIFO occupancy is 0 and mem_we=0 in state IDLE/WRITE.
- full and empty are derived from registered occupancy.

Reset mid-operation:
- Aborts any write or clear.
- No clear_done pulse is generated.

Test Plan:
- Draw (5,3,color 4) with mem_ready=1 -> exactly one transfer: mem_addr=965, mem_data=4, mem_we high 1 cycle, two edges after draw. Then empty=1.
- Draw (319,239,7) then (0,0,1) on consecutive cycles -> transfers at addr 76799 then 0, in order, on consecutive cycles.
- Draw (320,10,2) and (10,240,2) -> no mem_we, drop_count=2. Drive 300 off-screen draws -> drop_count stays 255.
- mem_ready=0, issue 10 draws at consecutive on-screen x -> full=1 after the FIFO fills, extra draws ignored, mem_addr stable. Raise mem_ready -> only accepted pixels written, in order, no duplicates.
- clear_start with clear_color=5 while one pixel is pending and 3 are queued:
  - Pending pixel written first.
  - Then 76800 writes of data 5, addr 0..76799.
  - clear_done pulses once.
  - Then the 3 queued pixels are written.
- Assert reset at clear address 1000 -> outputs return to reset values immediately; after release, no further writes and no clear_done.
